// File: rtl/core_ibex_fcov_pkg.sv
// Shared definitions for the Ibex functional-coverage event monitor:
// snapshot FSM states and channel indices of the standard pipeline taps.
package core_ibex_fcov_pkg;

   typedef enum logic {
      SnapIdle = 1'b0,
      SnapHold = 1'b1
   } snap_state_e;

   localparam int unsigned EvStallLdHz    = 0;
   localparam int unsigned EvStallMem     = 1;
   localparam int unsigned EvStallMultdiv = 2;
   localparam int unsigned EvStallBranch  = 3;
   localparam int unsigned EvStallJump    = 4;
   localparam int unsigned EvRfWbHz       = 5;
   localparam int unsigned EvPipeFlush    = 6;
   localparam int unsigned EvLsPmpExc     = 7;

endpackage

// File: rtl/core_ibex_fcov_event_chan.sv
// One event channel: saturating occurrence count, current run length,
// maximum run length and a sticky seen flag.
module core_ibex_fcov_event_chan #(
   parameter int unsigned CntWidth = 16,
   parameter int unsigned RunWidth = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                upd_i,
   input  logic                clear_i,
   input  logic                event_i,
   output logic [CntWidth-1:0] cnt_o,
   output logic [RunWidth-1:0] max_run_o,
   output logic                seen_o
);

   logic [CntWidth-1:0] cnt_reg, cnt_next;
   logic [RunWidth-1:0] run_reg, run_next, run_inc;
   logic [RunWidth-1:0] max_run_reg, max_run_next;
   logic                seen_reg, seen_next;

   // run_inc saturates, so max_run can never exceed all-ones either
   assign run_inc = (run_reg == '1) ? run_reg : run_reg + 1'b1;

   always_comb begin
      cnt_next     = cnt_reg;
      run_next     = run_reg;
      max_run_next = max_run_reg;
      seen_next    = seen_reg;
      if (clear_i) begin
         cnt_next     = '0;
         run_next     = '0;
         max_run_next = '0;
         seen_next    = 1'b0;
      end else if (upd_i) begin
         if (event_i) begin
            cnt_next  = (cnt_reg == '1) ? cnt_reg : cnt_reg + 1'b1;
            run_next  = run_inc;
            seen_next = 1'b1;
            if (run_inc > max_run_reg) begin
               max_run_next = run_inc;
            end
         end else begin
            run_next = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_reg     <= '0;
         run_reg     <= '0;
         max_run_reg <= '0;
         seen_reg    <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         run_reg     <= run_next;
         max_run_reg <= max_run_next;
         seen_reg    <= seen_next;
      end
   end

   assign cnt_o     = cnt_reg;
   assign max_run_o = max_run_reg;
   assign seen_o    = seen_reg;

endmodule

// File: rtl/core_ibex_fcov_event_monitor.sv
// N-channel coverage event monitor with coincidence detection and a
// valid/ready snapshot port that freezes all counters atomically.
module core_ibex_fcov_event_monitor
   import core_ibex_fcov_pkg::*;
#(
   parameter int unsigned NumEvents = 8,
   parameter int unsigned CntWidth  = 16,
   parameter int unsigned RunWidth  = 8
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          en_i,
   input  logic                          clear_i,
   input  logic [NumEvents-1:0]          event_i,
   output logic [NumEvents*CntWidth-1:0] cnt_o,
   output logic [NumEvents*RunWidth-1:0] max_run_o,
   output logic [NumEvents-1:0]          seen_o,
   output logic                          seen_all_o,
   output logic                          coincide_o,
   input  logic                          snap_req_i,
   output logic                          snap_valid_o,
   input  logic                          snap_ready_i,
   output logic [NumEvents*CntWidth-1:0] snap_cnt_o,
   output logic [NumEvents*RunWidth-1:0] snap_max_run_o
);

   logic upd;
   assign upd = en_i & ~clear_i;

   genvar gi;
   generate
      for (gi = 0; gi < NumEvents; gi++) begin : g_chan
         core_ibex_fcov_event_chan #(
            .CntWidth(CntWidth),
            .RunWidth(RunWidth)
         ) u_chan (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .upd_i    (upd),
            .clear_i  (clear_i),
            .event_i  (event_i[gi]),
            .cnt_o    (cnt_o[gi*CntWidth +: CntWidth]),
            .max_run_o(max_run_o[gi*RunWidth +: RunWidth]),
            .seen_o   (seen_o[gi])
         );
      end
   endgenerate

   assign seen_all_o = &seen_o;

   // Two-or-more detection without a full popcount
   logic ev_any, ev_multi;
   always_comb begin
      ev_any   = 1'b0;
      ev_multi = 1'b0;
      for (int k = 0; k < NumEvents; k++) begin
         ev_multi = ev_multi | (ev_any & event_i[k]);
         ev_any   = ev_any | event_i[k];
      end
   end

   logic coincide_reg;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         coincide_reg <= 1'b0;
      end else if (clear_i) begin
         coincide_reg <= 1'b0;
      end else if (upd && ev_multi) begin
         coincide_reg <= 1'b1;
      end
   end
   assign coincide_o = coincide_reg;

   snap_state_e state_reg, state_next;
   logic        capture;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= SnapIdle;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         SnapIdle: if (snap_req_i)   state_next = SnapHold;
         SnapHold: if (snap_ready_i) state_next = SnapIdle;
         default:                    state_next = SnapIdle;
      endcase
   end

   always_comb begin
      snap_valid_o = (state_reg == SnapHold);
      capture      = (state_reg == SnapIdle) && snap_req_i;
   end

   // Captures registered counts, so the request-cycle event is excluded
   logic [NumEvents*CntWidth-1:0] snap_cnt_reg;
   logic [NumEvents*RunWidth-1:0] snap_max_run_reg;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         snap_cnt_reg     <= '0;
         snap_max_run_reg <= '0;
      end else if (capture) begin
         snap_cnt_reg     <= cnt_o;
         snap_max_run_reg <= max_run_o;
      end
   end

   assign snap_cnt_o     = snap_cnt_reg;
   assign snap_max_run_o = snap_max_run_reg;

endmodule

// File: tb/tb_core_ibex_fcov_event_monitor.sv
// Directed bench for the fcov event monitor; a second instance with 4-bit
// counters shares the stimulus to exercise count saturation.
module tb_core_ibex_fcov_event_monitor;

   localparam int NE = 8;
   localparam int CW = 16;
   localparam int RW = 8;
   localparam int SCW = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic en, clear, snap_req, snap_ready;
   logic [NE-1:0] ev;

   logic [NE*CW-1:0] cnt, snap_cnt;
   logic [NE*RW-1:0] max_run, snap_max_run;
   logic [NE-1:0]    seen;
   logic             seen_all, coincide, snap_valid;

   logic [NE*SCW-1:0] s_cnt, s_snap_cnt;
   logic [NE*RW-1:0]  s_max_run, s_snap_max_run;
   logic [NE-1:0]     s_seen;
   logic              s_seen_all, s_coincide, s_snap_valid;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   always #5 clk = ~clk;

   core_ibex_fcov_event_monitor #(.NumEvents(NE), .CntWidth(CW), .RunWidth(RW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .event_i(ev),
      .cnt_o(cnt), .max_run_o(max_run), .seen_o(seen), .seen_all_o(seen_all),
      .coincide_o(coincide), .snap_req_i(snap_req), .snap_valid_o(snap_valid),
      .snap_ready_i(snap_ready), .snap_cnt_o(snap_cnt), .snap_max_run_o(snap_max_run)
   );

   core_ibex_fcov_event_monitor #(.NumEvents(NE), .CntWidth(SCW), .RunWidth(RW)) dut_sat (
      .clk_i(clk), .rst_ni(rst_n), .en_i(en), .clear_i(clear), .event_i(ev),
      .cnt_o(s_cnt), .max_run_o(s_max_run), .seen_o(s_seen), .seen_all_o(s_seen_all),
      .coincide_o(s_coincide), .snap_req_i(snap_req), .snap_valid_o(s_snap_valid),
      .snap_ready_i(snap_ready), .snap_cnt_o(s_snap_cnt), .snap_max_run_o(s_snap_max_run)
   );

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      chk_cnt++;
      if (obs === exp) begin
         pass_cnt++;
         $display("ok   %s obs=%0h exp=%0h", tag, obs, exp);
      end else begin
         $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_clear();
      clear = 1'b1;
      ev    = '0;
      step(1);
      clear = 1'b0;
   endtask

   task automatic burst(input int ch, input int n);
      ev = '0;
      ev[ch] = 1'b1;
      step(n);
      ev = '0;
      step(1);
   endtask

   function automatic logic [CW-1:0] cnt_of(input int k);
      return cnt[k*CW +: CW];
   endfunction

   function automatic logic [RW-1:0] mr_of(input int k);
      return max_run[k*RW +: RW];
   endfunction

   initial begin
      rst_n = 1'b0; en = 1'b0; clear = 1'b0; ev = '0;
      snap_req = 1'b0; snap_ready = 1'b0;
      step(2);
      check_val("reset_cnt", cnt, '0);
      check_val("reset_seen", seen, '0);
      check_val("reset_valid", snap_valid, 1'b0);
      rst_n = 1'b1;
      en    = 1'b1;
      step(1);

      // Five-cycle run on channel 0
      burst(0, 5);
      check_val("t1_cnt0", cnt_of(0), 5);
      check_val("t1_maxrun0", mr_of(0), 5);
      check_val("t1_seen", seen, 8'h01);
      check_val("t1_coincide", coincide, 1'b0);
      check_val("t1_seen_all", seen_all, 1'b0);

      // Saturation of a 4-bit counter, while the 8-bit run keeps going
      do_clear();
      burst(2, 20);
      check_val("t2_sat_cnt2", s_cnt[2*SCW +: SCW], 4'hF);
      check_val("t2_sat_maxrun2", s_max_run[2*RW +: RW], 20);
      check_val("t2_cnt2", cnt_of(2), 20);

      // Bursts 3 / 7 / 2 on channel 1
      do_clear();
      burst(1, 3);
      burst(1, 7);
      burst(1, 2);
      check_val("t3_cnt1", cnt_of(1), 12);
      check_val("t3_maxrun1", mr_of(1), 7);

      // Coincidence is sticky, clear beats simultaneous events
      do_clear();
      ev = 8'h11;
      step(1);
      ev = '0;
      step(1);
      check_val("t4_coincide", coincide, 1'b1);
      step(2);
      check_val("t4_coincide_sticky", coincide, 1'b1);
      clear = 1'b1;
      ev    = 8'hFF;
      step(1);
      clear = 1'b0;
      ev    = '0;
      check_val("t4_clr_cnt", cnt, '0);
      check_val("t4_clr_coincide", coincide, 1'b0);
      check_val("t4_clr_seen", seen, '0);
      step(1);
      check_val("t4_clr_hold", cnt, '0);

      // Snapshot holds while live counting continues
      ev = 8'h08;
      step(4);
      snap_req = 1'b1;
      step(1);
      snap_req = 1'b0;
      check_val("t5_valid", snap_valid, 1'b1);
      step(5);
      check_val("t5_snap_mid", snap_cnt[3*CW +: CW], 4);
      snap_req = 1'b1;
      step(4);
      snap_req = 1'b0;
      ev = '0;
      check_val("t5_snap_cnt3", snap_cnt[3*CW +: CW], 4);
      check_val("t5_snap_mr3", snap_max_run[3*RW +: RW], 4);
      check_val("t5_live_cnt3", cnt_of(3), 14);
      check_val("t5_valid_hold", snap_valid, 1'b1);
      snap_req   = 1'b1;
      snap_ready = 1'b1;
      step(1);
      snap_req   = 1'b0;
      snap_ready = 1'b0;
      check_val("t5_valid_drop", snap_valid, 1'b0);
      step(1);
      check_val("t5_no_requeue", snap_valid, 1'b0);

      // Enable gap inside a run, then async reset during HOLD
      do_clear();
      ev = 8'h20;
      step(3);
      en = 1'b0;
      step(4);
      check_val("t6_frozen_cnt5", cnt_of(5), 3);
      en = 1'b1;
      step(2);
      ev = '0;
      step(1);
      check_val("t6_cnt5", cnt_of(5), 5);
      check_val("t6_maxrun5", mr_of(5), 5);
      snap_req = 1'b1;
      step(1);
      snap_req = 1'b0;
      check_val("t6_snap_cnt5", snap_cnt[5*CW +: CW], 5);
      #2;
      rst_n = 1'b0;
      #1;
      check_val("t6_rst_valid", snap_valid, 1'b0);
      check_val("t6_rst_snap", snap_cnt, '0);
      check_val("t6_rst_cnt", cnt, '0);
      rst_n = 1'b1;
      step(1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/core_ibex_fcov_event_monitor.md
Name: core_ibex_fcov_event_monitor

Overview:
- Parametrised, synthesisable event-statistics monitor for Ibex functional coverage. It generalises the per-stage fcov signal taps (stalls, hazards, flushes, exceptions) into N independent event channels.
- Per channel it keeps a saturating occurrence count, a current consecutive-cycle run length, the maximum run seen, and a sticky seen bit.
- A valid/ready snapshot port lets the coverage collector sample all counters atomically.
- Bound alongside the stage fcov interfaces; it has no effect on core state.

Parameters:
- NumEvents, 8, number of event channels (1..32).
- CntWidth, 16, width of each occurrence counter.
- RunWidth, 8, width of each run-length and max-run counter.

Ports:
- clk_i  input  1  core clock.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  sampling enable; when low, all counters and runs hold.
- clear_i  input  1  synchronous clear of all statistics.
- event_i  input  NumEvents  per-channel event strobe, sampled each cycle.
- cnt_o  output  NumEvents*CntWidth  live occurrence counts; channel k at [k*CntWidth +: CntWidth].
- max_run_o  output  NumEvents*RunWidth  live maximum run length per channel.
- seen_o  output  NumEvents  sticky: channel fired at least once.
- seen_all_o  output  1  AND of seen_o.
- coincide_o  output  1  sticky: two or more channels fired in the same sampled cycle.
- snap_req_i  input  1  request a snapshot.
- snap_valid_o  output  1  snapshot data valid.
- snap_ready_i  input  1  collector accepts the snapshot.
- snap_cnt_o  output  NumEvents*CntWidth  frozen counts.
- snap_max_run_o  output  NumEvents*RunWidth  frozen max runs.

Behaviour:
- Reset (rst_ni low, async):
  - All counts, runs, max runs, seen_o, coincide_o, snap_* data and snap_valid_o go to 0.
  - FSM goes to IDLE.
- Update only on cycles with en_i=1 and clear_i=0.
- Per channel k, on an update cycle:
  - event_i[k]=1: cnt += 1, saturating at all-ones (no wrap). run += 1, saturating at all-ones. max_run = max(max_run, run+1), saturating. seen[k] = 1.
  - event_i[k]=0: run = 0; max_run unchanged.
- coincide_o is set when popcount(event_i) >= 2 on an update cycle; it is sticky.
- clear_i=1 (any en_i) zeroes counts, runs, max_run, seen_o and coincide_o on the next edge. clear_i has priority over events in the same cycle.
- clear_i does not touch snapshot registers or the FSM.
- en_i=0 freezes everything, including run. A run spanning a disabled gap continues when en_i returns.
- All live outputs are registered; they reflect events sampled up to the previous edge (1-cycle latency).
- Snapshot FSM, states IDLE and HOLD:
  - IDLE and snap_req_i=1: capture the current registered cnt_o/max_run_o into the snap regs and go to HOLD. snap_valid_o=1 from the next cycle.
  - The captured values exclude the event sampled in the request cycle.
  - HOLD: snap_valid_o=1 and snap data stable.
  - HOLD, snap_ready_i=1: go to IDLE; snap_valid_o=0 next cycle.
  - snap_req_i in HOLD is ignored; there is no queueing.
  - The FSM does not leave HOLD without ready.
  - req and ready arriving together in HOLD: go to IDLE only. A new capture needs req again in IDLE.
- Live counting continues during HOLD.
- RunWidth > CntWidth is legal; max_run is still capped only by its own width.

Decomposition:
- Shared package core_ibex_fcov_pkg:
  - snap_state_e {SnapIdle, SnapHold}.
  - Channel index constants for the standard taps: EvStallLdHz, EvStallMem, EvStallMultdiv, EvStallBranch, EvStallJump, EvRfWbHz, EvPipeFlush, EvLsPmpExc.
- One sub-module, core_ibex_fcov_event_chan: a single channel's saturating cnt/run/max_run/seen logic. It is instantiated NumEvents times via generate.
- Top level holds coincidence detection, the snapshot FSM and the snapshot registers.

Test Plan:
- Reset then event_i[0] high for 5 consecutive enabled cycles, then low → cnt[0]=5, max_run[0]=5, seen_o=8'h01, coincide_o=0.
- CntWidth=4, event_i[2] held for 20 cycles → cnt[2] saturates at 15, no wrap. RunWidth=8 → max_run[2]=20.
- Pulse channel 1 in bursts of 3, gap, 7, gap, 2 → max_run[1]=7, cnt[1]=12.
- event_i=8'h11 for one cycle → coincide_o=1 and stays 1. Then clear_i with event_i=8'hFF the same cycle → all counts 0 and coincide_o=0.
- Count 4 events on ch3, snap_req_i with ready low 10 cycles while ch3 keeps firing → snap_valid_o high, snap_cnt[3]=4 stable, live cnt[3]=14. Ready → valid drops next cycle.
- en_i low mid-run (run=3) for 4 cycles with event_i high, then enabled 2 more cycles → run continues, max_run=5, cnt=5. Async reset asserted mid-HOLD → snap_valid_o=0 immediately.
